// File: rtl/stream_processor_row_if.sv
// rtl/stream_processor_row_if.sv - sprite-row input and pixel readout handshake bundle
interface stream_processor_row_if #(
  parameter int SPRITE_W = 16,
  parameter int COLOR_W  = 8,
  parameter int DEPTH_W  = 8,
  parameter int X_W      = 8
);
  logic                        s_valid;
  logic                        s_ready;
  logic [SPRITE_W*COLOR_W-1:0] s_data;
  logic [X_W-1:0]              s_start_x;
  logic [DEPTH_W-1:0]          s_depth;
  logic                        s_force;
  logic                        o_valid;
  logic                        o_ready;
  logic [COLOR_W-1:0]          o_data;
  logic                        o_last;

  // master: sprite source and readout sink; slave: the row processor
  modport master (
    output s_valid, s_data, s_start_x, s_depth, s_force, o_ready,
    input  s_ready, o_valid, o_data, o_last
  );

  modport slave (
    input  s_valid, s_data, s_start_x, s_depth, s_force, o_ready,
    output s_ready, o_valid, o_data, o_last
  );
endinterface

// File: rtl/stream_processor_row.sv
// rtl/stream_processor_row.sv - depth-composited colour store for a run of scanline pixels
module stream_processor_row #(
  parameter int                 BASE_X      = 0,
  parameter int                 N_PIX       = 16,
  parameter int                 SPRITE_W    = 16,
  parameter int                 COLOR_W     = 8,
  parameter int                 DEPTH_W     = 8,
  parameter int                 X_W         = 8,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr,
  input  logic                   rd_start,
  output logic                   busy,
  stream_processor_row_if.slave  bus
);
  localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  typedef enum logic {IDLE, READ} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               idx_last;
  logic               accept;
  logic [N_PIX-1:0]   wr;
  logic [COLOR_W-1:0] texel_pix [N_PIX];
  logic [COLOR_W-1:0] color_q   [N_PIX];
  logic [DEPTH_W-1:0] depth_q   [N_PIX];

  assign idx_last = (idx_q == IDX_W'(N_PIX - 1));
  assign accept   = bus.s_valid && bus.s_ready;

  // Coordinates are widened by one bit so a start_x right of the pixel cannot wrap into a hit.
  for (genvar i = 0; i < N_PIX; i++) begin : g_pix
    localparam logic [X_W:0] PX = (X_W+1)'(BASE_X + i);
    logic [X_W:0]       diff;
    logic               hit;
    logic [COLOR_W-1:0] texel;

    assign diff = PX - {1'b0, bus.s_start_x};
    assign hit  = (PX >= {1'b0, bus.s_start_x}) && (diff < (X_W+1)'(SPRITE_W));

    always_comb begin
      texel = '0;
      for (int k = 0; k < SPRITE_W; k++) begin
        if (diff == (X_W+1)'(k)) texel = bus.s_data[k*COLOR_W +: COLOR_W];
      end
    end

    assign texel_pix[i] = texel;
    assign wr[i] = hit && (depth_q[i] <= bus.s_depth) &&
                   (bus.s_force || (bus.s_depth == '0) || (texel != '0));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PIX; i++) begin
      if (!reset_n || (state_q == IDLE && clr)) begin
        color_q[i] <= CLEAR_COLOR;
        depth_q[i] <= '0;
      end else if (accept && wr[i]) begin
        color_q[i] <= texel_pix[i];
        depth_q[i] <= bus.s_depth;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (!clr && rd_start) begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      READ: begin
        if (bus.o_ready) begin
          if (idx_last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even mid-readout.
  always_comb begin
    bus.s_ready = 1'b0;
    bus.o_valid = 1'b0;
    bus.o_last  = 1'b0;
    busy        = 1'b0;
    bus.o_data  = color_q[idx_q];
    if (reset_n) begin
      case (state_q)
        IDLE: bus.s_ready = !clr && !rd_start;
        READ: begin
          bus.o_valid = 1'b1;
          bus.o_last  = idx_last;
          busy        = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/stream_processor_row.md
Name: stream_processor_row

Overview:
- Parametrised successor of the single-pixel stream processor. Owns a contiguous run of N_PIX screen pixels on one scanline.
- Depth-composites incoming sprite rows (one per valid/ready handshake) into a per-pixel colour/depth store.
- Supports a one-cycle clear and a serial readout stream that feeds the scanline output path.

Parameters:
- BASE_X, 0, absolute screen x of pixel 0; pixel i sits at BASE_X+i
- N_PIX, 16, pixels owned by this row (power of 2 not required, >=1)
- SPRITE_W, 16, texels per sprite row
- COLOR_W, 8, colour bits per texel/pixel; colour value 0 = transparent key
- DEPTH_W, 8, depth bits
- X_W, 8, width of x coordinates
- CLEAR_COLOR, 0, colour loaded by reset and by clear

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- clr  in  1  clear pulse: all depth<=0, all colour<=CLEAR_COLOR
- rd_start  in  1  start serial readout of the N_PIX colours
- s_valid  in  1  sprite row valid
- s_ready  out  1  sprite row accepted when s_valid&&s_ready
- s_data  in  SPRITE_W*COLOR_W  texels; texel k = s_data[k*COLOR_W +: COLOR_W]
- s_start_x  in  X_W  absolute screen x of texel 0
- s_depth  in  DEPTH_W  depth of this sprite; larger = nearer
- s_force  in  1  1 = ignore transparency key (write colour 0 as well)
- o_valid  out  1  readout data valid
- o_ready  in  1  downstream ready
- o_data  out  COLOR_W  pixel colour, pixel 0 first
- o_last  out  1  high with the pixel N_PIX-1 beat
- busy  out  1  high while in READ state

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset (reset_n low at a clk edge):
  - state<=IDLE, read index<=0.
  - All depth<=0, all colour<=CLEAR_COLOR.
  - While reset_n is low, s_ready=0, o_valid=0, o_last=0, busy=0. This holds even mid-readout; the partial stream is abandoned with no o_last.
- States: IDLE, READ.
- IDLE, priority clr > rd_start > sprite:
  - s_ready = (state==IDLE) && !clr && !rd_start. Combinational on clr/rd_start only, never on s_valid.
  - clr: the clear takes effect at the next edge (1-cycle latency). No sprite is accepted that cycle.
  - rd_start (clr low): next state READ, index<=0.
  - Sprite handshake: every pixel i evaluates its update in parallel. Stored values update at the same edge; the result is visible to the next readout or sprite.
- Per-pixel update for pixel i, with x = BASE_X+i and all arithmetic X_W+1 bits unsigned so there is no wrap:
  - hit when x >= s_start_x and (x - s_start_x) < SPRITE_W.
  - texel t = texel index (x - s_start_x).
  - write when hit && depth_i <= s_depth && (s_force || s_depth==0 || t != 0).
  - On write: colour_i<=t, depth_i<=s_depth. Equal depth means the later sprite wins.
  - Pixels outside the sprite span are untouched. This is a right-edge bound that the single-pixel version lacked.
- READ:
  - o_valid=1, o_data=colour[index], o_last=(index==N_PIX-1), busy=1, s_ready=0.
  - On o_valid&&o_ready: index++.
  - On the handshake with o_last: state<=IDLE, index<=0.
  - o_ready low stalls the stream with o_data held stable.
- clr and rd_start are ignored while in READ.
- Readout does not modify the store. Repeated readouts return identical data.
- Sprite latency 1 cycle. Back-to-back sprites are accepted every cycle in IDLE.

Test Plan:
- Reset, then immediate rd_start with o_ready=1 -> 16 beats of 0x00, o_last on beat 16 only, busy falls on the cycle after the last beat.
- BASE_X=0, sprite start_x=4, depth=5, texels k=0..15 = k+1 -> pixels 0-3 stay 0; pixels 4..15 = 1..12; depth 5 at pixels 4..15.
- Follow with start_x=0, depth=3, all texels 0xAA -> no change (3<5) on pixels 4..15; pixels 0-3 = 0xAA.
- Sprite depth=5, texels all 0 with s_force=0 -> no change. Same sprite with s_force=1 -> pixels 4..15 = 0.
- clr and s_valid high in the same cycle -> s_ready=0, sprite not taken. Next readout gives all CLEAR_COLOR.
- Readout with o_ready toggling 1/0 each cycle -> o_data stable while stalled, 16 beats total. Then reset_n low at beat 8 -> o_valid 0 next cycle, state IDLE, store cleared.
